// File: rtl/interrupt_responder_if.sv
// Purpose : bundles the CPU/device-facing signals of the interrupt responder.
// Latency : none (wires only).
// Backpressure: none; ack/eoi are single-cycle strobes qualified by the responder state.
// Ports   : src/en_we/en_wd/stat_clr/ack/eoi driven by master; statout/intout/irq/
//           vector/vec_valid driven by slave (the responder).
interface interrupt_responder_if;
  logic [7:0] src;
  logic       en_we;
  logic [7:0] en_wd;
  logic [7:0] stat_clr;
  logic       ack;
  logic       eoi;
  logic [7:0] statout;
  logic [7:0] intout;
  logic       irq;
  logic [2:0] vector;
  logic       vec_valid;

  modport master (
    output src, en_we, en_wd, stat_clr, ack, eoi,
    input  statout, intout, irq, vector, vec_valid
  );

  modport slave (
    input  src, en_we, en_wd, stat_clr, ack, eoi,
    output statout, intout, irq, vector, vec_valid
  );
endinterface

// File: rtl/interrupt_responder.sv
// Purpose : 8-source interrupt responder with pending/enable registers, fixed
//           lowest-index priority and an IDLE/REQ/SERVICE handshake with the CPU.
// Latency : src pulse in cycle n -> statout after edge n -> irq high in cycle n+2.
// Backpressure: irq is held until ack (or until nothing enabled is pending);
//           vector is held until eoi; ack/eoi in other states are ignored.
// Ports   : clk, reset (sync, active-high); bus (slave modport) carries src,
//           en_we/en_wd, stat_clr, ack, eoi in and statout, intout, irq,
//           vector, vec_valid out.
module interrupt_responder (
  input logic                  clk,
  input logic                  reset,
  interrupt_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pend;
  logic [7:0] enab;
  logic [7:0] active;
  logic [7:0] ack_clear;
  logic [2:0] pri_idx;
  logic [2:0] vec;
  logic       req_cond;
  logic       take;

  // Priority and request are computed from registered pend/enab only, so a
  // src pulse in the ack cycle cannot steer the vector choice.
  always_comb begin
    active   = pend & enab;
    req_cond = |active;
    pri_idx  = 3'd0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) begin
        pri_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (req_cond) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        // An ack with nothing left to service is treated like no ack.
        if (bus.ack && req_cond) begin
          take      = 1'b1;
          state_nxt = SERVICE;
        end else if (!req_cond) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ack_clear = take ? (8'h01 << pri_idx) : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend  <= 8'h00;
      enab  <= 8'h00;
      vec   <= 3'd0;
    end else begin
      state <= state_nxt;
      // A new source event wins over any clear landing in the same cycle.
      pend  <= bus.src | (pend & ~bus.stat_clr & ~ack_clear);
      if (bus.en_we) begin
        enab <= bus.en_wd;
      end
      if (take) begin
        vec <= pri_idx;
      end
    end
  end

  assign bus.statout   = pend;
  assign bus.intout    = enab;
  assign bus.irq       = (state == REQ);
  assign bus.vec_valid = (state == SERVICE);
  assign bus.vector    = vec;

endmodule
